uart_rx_stdin: RTL and testbench

//  UART receiver feeding the verifuck core's stdin (',' instruction); receive-side counterpart of uart_tx_pin.

---
 rtl/verifuck_pkg.sv | 8 +
 rtl/stdin_fifo.sv | 41 ++++
 rtl/uart_rx_stdin.sv | 133 +++++++++++++
 tb/tb_uart_rx_stdin.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verifuck_pkg.sv
// Shared types for the verifuck stdin path: receiver FSM states and byte width.
package verifuck_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } rx_state_e;
endpackage

// File: rtl/stdin_fifo.sv
// First-word-fall-through byte FIFO; dout always shows the head entry.
module stdin_fifo
  import verifuck_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
endmodule

// File: rtl/uart_rx_stdin.sv
// UART receiver feeding the core's stdin through a small FWFT FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_rx_stdin
  import verifuck_pkg::*;
#(
  parameter int UART_RX_BAUD = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_pin,
  output logic [BYTE_W-1:0] stdin,
  output logic              stdin_valid,
  input  logic              stdin_ready,
  input  logic              clear_err,
  output logic              overrun,
  output logic              frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int HALF = UART_RX_BAUD / 2;
  localparam int CW   = $clog2(UART_RX_BAUD);

  logic [1:0]        sync_q;
  logic              rx_s;
  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        idx_q;
  logic [BYTE_W-1:0] shreg_q;
  logic              push_q, overrun_q, frame_q;
  logic              cnt_last, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic              ovr_set, frame_set, push_ok;

  assign rx_s      = sync_q[1];
  assign cnt_last  = (cnt_q == CW'(UART_RX_BAUD - 1));
  assign fifo_pop  = !fifo_empty && stdin_ready;
  // A pop in the push cycle frees a slot, so a full FIFO still accepts the byte.
  assign fifo_push = push_q && (!fifo_full || fifo_pop);
  assign ovr_set   = push_q && fifo_full && !fifo_pop;
  assign frame_set = (state_q == STOP) && cnt_last && !rx_s;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, parity_q, par_set;
  assign par_set    = (state_q == PARITY) && cnt_last && (rx_s != ^shreg_q);
  assign push_ok    = !par_bad_q;
  assign parity_err = parity_q;
`else
  assign push_ok    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      push_q    <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], uart_rx_pin};
      push_q    <= 1'b0;
      overrun_q <= ovr_set | (overrun_q & ~clear_err);
      frame_q   <= frame_set | (frame_q & ~clear_err);
`ifdef UART_RX_PARITY_EN
      parity_q  <= par_set | (parity_q & ~clear_err);
`endif
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == CW'(HALF - 1)) begin
          state_q <= rx_s ? IDLE : DATA;
          cnt_q   <= '0;
          idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad_q <= 1'b0;
`endif
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_last) begin
          shreg_q[idx_q] <= rx_s;
          cnt_q          <= '0;
          idx_q          <= idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_q <= PARITY;
`else
          if (idx_q == 3'd7) state_q <= STOP;
`endif
        end else cnt_q <= cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt_last) begin
          par_bad_q <= par_set;
          cnt_q     <= '0;
          state_q   <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        STOP: if (cnt_last) begin
          cnt_q <= '0;
          if (rx_s) begin
            push_q  <= push_ok;
            state_q <= IDLE;
          end else state_q <= BREAK;
        end else cnt_q <= cnt_q + 1'b1;
        // A held-low line must return high before a new start bit counts.
        BREAK: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  stdin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (shreg_q),
    .pop   (fifo_pop),
    .dout  (stdin),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign stdin_valid = !fifo_empty;
  assign overrun     = overrun_q;
  assign frame_err   = frame_q;
endmodule

// File: tb/tb_uart_rx_stdin.sv
// Bench for uart_rx_stdin: frame-level event model plus directed and random serial traffic.
module tb_uart_rx_stdin;
  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int HALF  = BAUD / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Edge offsets from the cycle the start bit is driven: 2 sync flops, 1 idle detect,
  // HALF to mid start bit, then one BAUD per following bit.
  localparam int STOP_SMP = 3 + HALF + (NB - 1) * BAUD;
  localparam int PUSH_AT  = STOP_SMP + 1;
  localparam int PAR_SMP  = STOP_SMP - BAUD;

  logic       clk = 1'b0, rst_n = 1'b0, pin = 1'b1;
  logic       stdin_ready = 1'b0, clear_err = 1'b0;
  logic [7:0] stdin;
  logic       stdin_valid, overrun, frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_stdin #(.UART_RX_BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_pin (pin),
    .stdin       (stdin),
    .stdin_valid (stdin_valid),
    .stdin_ready (stdin_ready),
    .clear_err   (clear_err),
    .overrun     (overrun),
    .frame_err   (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {int cyc; int kind; logic [7:0] b;} ev_t;  // kind 0 push, 1 frame, 2 parity
  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_ovr = 0, m_fe = 0, m_pe = 0;
  int         cyc = 0, checks = 0, errors = 0;
  bit         rnd_en = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Model: FIFO as a queue, frame outcomes as timed events.
  initial begin : model
    bit pop, pushv, oset, fset, pset;
    logic [7:0] pb, tmp;
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete(); evq.delete();
        m_ovr = 0; m_fe = 0; m_pe = 0;
      end else begin
        pop = (mq.size() != 0) && stdin_ready;
        pushv = 0; fset = 0; pset = 0; pb = '0;
        while (evq.size() != 0 && evq[0].cyc <= cyc) begin
          e = evq.pop_front();
          if (e.cyc == cyc) begin
            if (e.kind == 0) begin pushv = 1; pb = e.b; end
            else if (e.kind == 1) fset = 1;
            else pset = 1;
          end
        end
        oset = pushv && (mq.size() == DEPTH) && !pop;
        if (pop) tmp = mq.pop_front();
        if (pushv && !oset) mq.push_back(pb);
        m_ovr = oset || (m_ovr && !clear_err);
        m_fe  = fset || (m_fe && !clear_err);
        m_pe  = pset || (m_pe && !clear_err);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmp("rst_valid", stdin_valid, 0);
        cmp("rst_stdin", stdin, 0);
        cmp("rst_overrun", overrun, 0);
        cmp("rst_frame_err", frame_err, 0);
      end else begin
        cmp("valid", stdin_valid, mq.size() != 0);
        if (mq.size() != 0) cmp("stdin", stdin, mq[0]);
        cmp("overrun", overrun, m_ovr);
        cmp("frame_err", frame_err, m_fe);
`ifdef UART_RX_PARITY_EN
        cmp("parity_err", parity_err, m_pe);
`endif
      end
    end
  end

  initial begin : rnd_drv
    forever begin
      @(posedge clk); #2;
      if (rnd_en) begin
        stdin_ready = ($urandom_range(0, 1) == 1);
        clear_err   = ($urandom_range(0, 15) == 0);
      end
    end
  end

  // Called right after a rising edge; schedules the frame's outcome and drives it.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int hold_low);
    logic [10:0] bits;
    int k;
    k = cyc;
    bits = '0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = par_ok ? ^b : ~^b;
    bits[10] = stop_ok;
    if (!par_ok) evq.push_back(ev_t'{k + PAR_SMP, 2, b});
`else
    bits[9] = stop_ok;
`endif
    if (!stop_ok) evq.push_back(ev_t'{k + STOP_SMP, 1, b});
    else if (par_ok) evq.push_back(ev_t'{k + PUSH_AT, 0, b});
    for (int j = 0; j < NB; j++) begin
      pin = bits[j];
      step(BAUD);
    end
    if (!stop_ok) begin
      step(hold_low);
      pin = 1'b1;
      step(2);
    end
  endtask

  task automatic drive_partial(input logic [7:0] b, input int nbits);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < nbits; j++) begin
      pin = bits[j];
      step(BAUD);
    end
  endtask

  task automatic wait_valid(input int lim, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = stdin_valid;
    end
    if (!ok) cmp({name, "_timeout"}, 0, 1);
  endtask

  initial begin : main
    rst_n = 1'b0;
    step(3);
    @(negedge clk);
    cmp("reset_stdin", stdin, 8'h00);
    cmp("reset_valid", stdin_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);

    // Single byte, consumer always ready: valid for exactly one cycle.
    stdin_ready = 1'b1;
    send_frame(8'h41, 1, 1, 0);
    wait_valid(20, "t1");
    cmp("t1_byte", stdin, 8'h41);
    @(negedge clk);
    cmp("t1_pulse", stdin_valid, 0);
    cmp("t1_flags", {overrun, frame_err}, 2'b00);
    @(posedge clk); #1;

    // One-cycle glitch is a false start.
    pin = 1'b0; step(1); pin = 1'b1;
    step(12);
    @(negedge clk);
    cmp("t2_valid", stdin_valid, 0);
    cmp("t2_flags", {overrun, frame_err}, 2'b00);
    @(posedge clk); #1;

    // Five back-to-back bytes into a depth-4 FIFO with no consumer.
    stdin_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1, 0);
    step(4);
    @(negedge clk);
    cmp("t3_overrun", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      cmp("t3_valid", stdin_valid, 1);
      cmp("t3_drain", stdin, 32'(i));
      @(posedge clk); #1;
      stdin_ready = 1'b1;
      step(1);
      stdin_ready = 1'b0;
    end
    @(negedge clk);
    cmp("t3_empty", stdin_valid, 0);
    @(posedge clk); #1;
    clear_err = 1'b1; step(1); clear_err = 1'b0;
    @(negedge clk);
    cmp("t3_cleared", overrun, 0);
    @(posedge clk); #1;

    // Bad stop bit then a long low line; clearing mid-break must stay clear.
    fork
      send_frame(8'h55, 0, 1, 50);
      begin
        step(44);
        @(negedge clk);
        cmp("t4_ferr", frame_err, 1);
        cmp("t4_nopush", stdin_valid, 0);
        @(posedge clk); #1;
        clear_err = 1'b1; step(1); clear_err = 1'b0;
      end
    join
    @(negedge clk);
    cmp("t4_no_retrigger", frame_err, 0);
    @(posedge clk); #1;

    // Reset during data bit 3 loses the partial frame.
    drive_partial(8'h3C, 5);
    rst_n = 1'b0; pin = 1'b1;
    step(2);
    @(negedge clk);
    cmp("t5_rst_valid", stdin_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    send_frame(8'hA5, 1, 1, 0);
    step(4);
    @(negedge clk);
    cmp("t5_valid", stdin_valid, 1);
    cmp("t5_byte", stdin, 8'hA5);
    @(posedge clk); #1;
    stdin_ready = 1'b1; step(1); stdin_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1, 0, 0);
    step(4);
    @(negedge clk);
    cmp("t6_perr", parity_err, 1);
    cmp("t6_nopush", stdin_valid, 0);
    @(posedge clk); #1;
    clear_err = 1'b1; step(1); clear_err = 1'b0;
    send_frame(8'h03, 1, 1, 0);
    step(4);
    @(negedge clk);
    cmp("t6_byte", stdin, 8'h03);
    cmp("t6_valid", stdin_valid, 1);
    @(posedge clk); #1;
    stdin_ready = 1'b1; step(1); stdin_ready = 1'b0;
`endif

    // Random traffic: data, bad stops, gaps, consumer stalls and clears.
    rnd_en = 1;
    for (int n = 0; n < 60; n++) begin
      bit sok, pok;
      sok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 7) != 0);
`else
      pok = 1;
`endif
      send_frame(8'($urandom), sok, pok, $urandom_range(0, 10));
      step($urandom_range(0, 5));
    end
    rnd_en = 0;
    stdin_ready = 1'b1;
    clear_err = 1'b0;
    step(60);
    @(negedge clk);
    cmp("final_empty", stdin_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
